piece_motion_ctrl: RTL



---
 rtl/piece_motion_ctrl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/piece_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : piece_motion_ctrl
// Purpose  : Falling-block position tracker with debounced moves, frame-paced
//            gravity, landing/respawn sequencing and a per-pixel hit test.
// Revision : 1.0 - initial release
// ============================================================================
module piece_motion_ctrl #(
    parameter int BLOCK_SIZE  = 20,
    parameter int BOARD_X0    = 220,
    parameter int BOARD_W     = 10,
    parameter int BOARD_H     = 24,
    parameter int GRAVITY_DIV = 30,
    parameter int DEB_FRAMES  = 2,
    parameter int LAND_FRAMES = 15
) (
    input  logic       iVGA_CLK,
    input  logic       iRST_n,
    input  logic       iVS,
    input  logic [3:0] move,
    input  logic [9:0] x_current,
    input  logic [8:0] y_current,
    output logic       isInSquare,
    output logic [3:0] piece_col,
    output logic [4:0] piece_row,
    output logic       landed
);

    localparam int c_DW = $clog2(DEB_FRAMES) + 1;
    localparam int c_GW = (GRAVITY_DIV > 1) ? $clog2(GRAVITY_DIV) : 1;
    localparam int c_LW = (LAND_FRAMES > 1) ? $clog2(LAND_FRAMES) : 1;

    localparam logic [c_DW-1:0] c_DEB       = c_DW'(DEB_FRAMES);
    localparam logic [c_GW-1:0] c_GRAV_LAST = c_GW'(GRAVITY_DIV - 1);
    localparam logic [c_LW-1:0] c_LAND_LAST = c_LW'(LAND_FRAMES - 1);
    localparam logic [3:0]      c_COL_MAX   = 4'(BOARD_W - 1);
    localparam logic [3:0]      c_COL_SPAWN = 4'(BOARD_W / 2);
    localparam logic [4:0]      c_ROW_MAX   = 5'(BOARD_H - 1);

    typedef enum logic [0:0] {
        S_FALL   = 1'b0,
        S_LANDED = 1'b1
    } state_t;

    logic       r_vs_s1, r_vs_s2, r_vs_s3, r_ftick;
    logic [3:0] r_mv_s1, r_mv_s2;
    logic [3:0] w_press;

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_vs_s1 <= 1'b0;
            r_vs_s2 <= 1'b0;
            r_vs_s3 <= 1'b0;
            r_ftick <= 1'b0;
            r_mv_s1 <= '0;
            r_mv_s2 <= '0;
        end else begin
            r_vs_s1 <= iVS;
            r_vs_s2 <= r_vs_s1;
            r_vs_s3 <= r_vs_s2;
            r_ftick <= r_vs_s3 & ~r_vs_s2;
            r_mv_s1 <= move;
            r_mv_s2 <= r_mv_s1;
        end
    end

    // A press is the debounced rising flip, consumed on the tick it occurs.
    for (genvar gi = 0; gi < 4; gi++) begin : g_deb
        logic [c_DW-1:0] r_cnt;
        logic [c_DW-1:0] w_cnt_inc;
        logic            r_lvl;
        logic            w_flip;

        assign w_cnt_inc    = r_cnt + c_DW'(1);
        assign w_flip       = r_ftick && (r_mv_s2[gi] != r_lvl) && (w_cnt_inc == c_DEB);
        assign w_press[gi]  = w_flip && r_mv_s2[gi];

        always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
            if (!iRST_n) begin
                r_cnt <= '0;
                r_lvl <= 1'b0;
            end else if (r_ftick) begin
                if (r_mv_s2[gi] == r_lvl) begin
                    r_cnt <= '0;
                end else if (w_cnt_inc == c_DEB) begin
                    r_cnt <= '0;
                    r_lvl <= r_mv_s2[gi];
                end else begin
                    r_cnt <= w_cnt_inc;
                end
            end
        end
    end

    state_t          r_state, w_state_nxt;
    logic [3:0]      r_col, w_col_nxt;
    logic [4:0]      r_row, w_row_nxt;
    logic [c_GW-1:0] r_gcnt, w_gcnt_nxt;
    logic [c_LW-1:0] r_lcnt, w_lcnt_nxt;
    logic            r_landed, w_landed_nxt;
    logic            w_grav_exp;
    logic            w_step;

    assign w_grav_exp = (r_gcnt == c_GRAV_LAST);
    assign w_step     = w_press[2] || w_grav_exp;

    always_comb begin
        w_state_nxt  = r_state;
        w_col_nxt    = r_col;
        w_row_nxt    = r_row;
        w_gcnt_nxt   = r_gcnt;
        w_lcnt_nxt   = r_lcnt;
        w_landed_nxt = 1'b0;
        if (r_ftick) begin
            case (r_state)
                S_FALL: begin
                    if (w_press[0] ^ w_press[1]) begin
                        if (w_press[0] && (r_col != 4'd0)) begin
                            w_col_nxt = r_col - 4'd1;
                        end else if (w_press[1] && (r_col < c_COL_MAX)) begin
                            w_col_nxt = r_col + 4'd1;
                        end
                    end
                    w_gcnt_nxt = w_grav_exp ? '0 : r_gcnt + c_GW'(1);
                    if (w_press[2]) begin
                        w_gcnt_nxt = '0;
                    end
                    if (w_press[3]) begin
                        w_row_nxt    = c_ROW_MAX;
                        w_state_nxt  = S_LANDED;
                        w_landed_nxt = 1'b1;
                    end else if (w_step) begin
                        if (r_row < c_ROW_MAX) begin
                            w_row_nxt = r_row + 5'd1;
                        end else begin
                            w_state_nxt  = S_LANDED;
                            w_landed_nxt = 1'b1;
                        end
                    end
                    if (w_landed_nxt) begin
                        w_gcnt_nxt = '0;
                        w_lcnt_nxt = '0;
                    end
                end
                S_LANDED: begin
                    w_gcnt_nxt = '0;
                    if (r_lcnt == c_LAND_LAST) begin
                        w_col_nxt   = c_COL_SPAWN;
                        w_row_nxt   = 5'd0;
                        w_lcnt_nxt  = '0;
                        w_state_nxt = S_FALL;
                    end else begin
                        w_lcnt_nxt = r_lcnt + c_LW'(1);
                    end
                end
                default: w_state_nxt = S_FALL;
            endcase
        end
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_state  <= S_FALL;
            r_col    <= c_COL_SPAWN;
            r_row    <= 5'd0;
            r_gcnt   <= '0;
            r_lcnt   <= '0;
            r_landed <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_col    <= w_col_nxt;
            r_row    <= w_row_nxt;
            r_gcnt   <= w_gcnt_nxt;
            r_lcnt   <= w_lcnt_nxt;
            r_landed <= w_landed_nxt;
        end
    end

    logic [9:0] w_px, w_py, w_px_end, w_py_end, w_y;

    assign w_px     = 10'(BOARD_X0) + 10'(r_col) * 10'(BLOCK_SIZE);
    assign w_py     = 10'(r_row) * 10'(BLOCK_SIZE);
    assign w_px_end = w_px + 10'(BLOCK_SIZE);
    assign w_py_end = w_py + 10'(BLOCK_SIZE);
    assign w_y      = {1'b0, y_current};

    assign isInSquare = (x_current >= w_px) && (x_current < w_px_end) &&
                        (w_y >= w_py) && (w_y < w_py_end);

    assign piece_col = r_col;
    assign piece_row = r_row;
    assign landed    = r_landed;

endmodule
`default_nettype wire
